// File: rtl/mic1_pkg.sv
// Shared definitions for the MIC-1 microsequencer: MIR field layout, ALU codes,
// sequencer states and a decode helper.
package mic1_pkg;

  localparam logic [8:0] HALT_ADDR = 9'h1FF;

  localparam int NA_LSB   = 27;
  localparam int JMPC_BIT = 26;
  localparam int JAMN_BIT = 25;
  localparam int JAMZ_BIT = 24;
  localparam int ALU_LSB  = 16;
  localparam int C_LSB    = 7;
  localparam int WR_BIT   = 6;
  localparam int RD_BIT   = 5;
  localparam int FE_BIT   = 4;
  localparam int B_LSB    = 0;

  // {SLL8,SRA1,F0,F1,ENA,ENB,INVA,INC}
  localparam logic [7:0] ALU_A        = 8'h18;
  localparam logic [7:0] ALU_B        = 8'h14;
  localparam logic [7:0] ALU_A_PLUS_B = 8'h3C;
  localparam logic [7:0] ALU_B_PLUS_1 = 8'h35;
  localparam logic [7:0] ALU_B_MINUS_A = 8'h3F;
  localparam logic [7:0] ALU_A_AND_B  = 8'h0C;
  localparam logic [7:0] ALU_ZERO     = 8'h10;

  typedef enum logic [2:0] {
    S_FETCH, S_LATCH, S_EXEC, S_MEM_WAIT, S_NEXT, S_HALT
  } state_t;

  typedef struct packed {
    logic [8:0] next_addr;
    logic       jmpc;
    logic       jamn;
    logic       jamz;
    logic [7:0] alu;
    logic [8:0] c;
    logic       wr;
    logic       rd;
    logic       fe;
    logic [3:0] b;
  } mir_t;

  function automatic mir_t mir_decode(logic [35:0] w);
    mir_t d;
    d.next_addr = w[NA_LSB +: 9];
    d.jmpc      = w[JMPC_BIT];
    d.jamn      = w[JAMN_BIT];
    d.jamz      = w[JAMZ_BIT];
    d.alu       = w[ALU_LSB +: 8];
    d.c         = w[C_LSB +: 9];
    d.wr        = w[WR_BIT];
    d.rd        = w[RD_BIT];
    d.fe        = w[FE_BIT];
    d.b         = w[B_LSB +: 4];
    return d;
  endfunction

endpackage

// File: rtl/mic1_next_addr.sv
// Next-MPC logic: NEXT_ADDRESS with the JAM conditions ORed in. Pure OR, no carry.
module mic1_next_addr (
  input  logic [8:0] next_addr,
  input  logic       jmpc,
  input  logic       jamn,
  input  logic       jamz,
  input  logic       n_flag,
  input  logic       z_flag,
  input  logic [7:0] mbr,
  output logic [8:0] next_mpc
);

  logic       hi_jam;
  logic [7:0] lo_or;

  assign hi_jam   = (jamn & n_flag) | (jamz & z_flag);
  assign lo_or    = jmpc ? mbr : 8'h00;
  assign next_mpc = {next_addr[8] | hi_jam, next_addr[7:0] | lo_or};

endmodule

// File: rtl/mic1_microsequencer.sv
// MIC-1 microsequencer: fetch/latch/exec/next loop over a synchronous control
// store, with a memory stall state and a terminal halt.
module mic1_microsequencer #(
  parameter int         ADDR_W    = 9,
  parameter int         WORD_W    = 36,
  parameter logic [8:0] HALT_ADDR = mic1_pkg::HALT_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] cs_addr,
  input  logic [WORD_W-1:0] cs_data,
  input  logic              N,
  input  logic              Z,
  input  logic [7:0]        mbr,
  input  logic              mem_done,
  output logic [7:0]        alu_select,
  output logic [8:0]        c_en,
  output logic [3:0]        b_sel,
  output logic              mem_write,
  output logic              mem_read,
  output logic              mem_fetch,
  output logic              n_flag,
  output logic              z_flag,
  output logic              halted
);
  import mic1_pkg::*;

  state_t            state, state_n;
  logic [ADDR_W-1:0] mpc;
  logic [WORD_W-1:0] mir;
  mir_t              f;
  logic [8:0]        next_mpc;
  logic              exec;
  logic              halt_hit;

  assign f = mir_decode(mir);

  mic1_next_addr u_next_addr (
    .next_addr (f.next_addr),
    .jmpc      (f.jmpc),
    .jamn      (f.jamn),
    .jamz      (f.jamz),
    .n_flag    (n_flag),
    .z_flag    (z_flag),
    .mbr       (mbr),
    .next_mpc  (next_mpc)
  );

  // Halt only on the literal halt address with no jump modifiers at all.
  assign halt_hit = (f.next_addr == HALT_ADDR) && !(f.jmpc || f.jamn || f.jamz);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_FETCH:    state_n = S_LATCH;
      S_LATCH:    state_n = S_EXEC;
      S_EXEC:     state_n = (f.wr || f.rd || f.fe) ? S_MEM_WAIT : S_NEXT;
      S_MEM_WAIT: if (mem_done) state_n = S_NEXT;
      S_NEXT:     state_n = halt_hit ? S_HALT : S_FETCH;
      S_HALT:     state_n = S_HALT;
      default:    state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mpc    <= '0;
      mir    <= '0;
      n_flag <= 1'b0;
      z_flag <= 1'b0;
    end else begin
      if (state == S_LATCH) mir <= cs_data;
      if (state == S_EXEC) begin
        n_flag <= N;
        z_flag <= Z;
      end
      if (state == S_NEXT) mpc <= next_mpc;
    end
  end

  assign exec       = (state == S_EXEC);
  assign cs_addr    = mpc;
  assign alu_select = f.alu;
  assign b_sel      = f.b;
  assign c_en       = exec ? f.c : 9'h000;
  assign mem_write  = exec & f.wr;
  assign mem_read   = exec & f.rd;
  assign mem_fetch  = exec & f.fe;
  assign halted     = (state == S_HALT);

endmodule
